vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//  Receive end of the VGA link: samples HS/VS/RGB as driven by the display timing generator (same clk),
//  recovers pixel coordinates, checks sync timing, locks, then writes each active pixel as a 2-bit colour
//  code into the video buffer write port. Used for loopback self-test and frame capture.
// PARAMETERS
//  HSYNC_BITS 11  width of x address / horizontal counter
//  VSYNC_BITS 11  width of y address / vertical counter
//  HD/HF/HR/HB 1280/48/112/248  h display, front porch, sync, back porch (clk); HMAX=HD+HF+HR+HB-1
//  VD/VF/VR/VB 1024/1/3/38      v equivalents (lines); VMAX=VD+VF+VR+VB-1
//  LOCK_FRAMES 2  consecutive error-free frames required before LOCKED (>=1)
// PORTS
//  clk           in   1   clock
//  arstn         in   1   reset, asynchronous, active-low
//  vga_hs_i      in   1   horizontal sync, active high for HR clk
//  vga_vs_i      in   1   vertical sync, active high for VR lines
//  rgb_i         in   12  {R[11:8],G[7:4],B[3:0]}
//  we_o          out  1   pixel write strobe (LOCKED and active area only)
//  addr_x_o      out  HSYNC_BITS  pixel column 0..HD-1
//  addr_y_o      out  VSYNC_BITS  pixel row 0..VD-1
//  color_o       out  2   BLACK=0 WHITE=1 BLUE=2 GREEN=3
//  locked_o      out  1   high in LOCKED state
//  frame_start_o out  1   1-clk pulse on VS rise while LOCKED
//  err_o         out  1   1-clk pulse on any timing violation in CHECK/LOCKED
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=SEARCH, counters 0, sync stages 0.
//  - Inputs pass two flop stages s1->s2; s3 holds previous s2 (edge detect). hrise=s2.hs&!s3.hs,
//    hfall=!s2.hs&s3.hs, vrise likewise. Pin sample at edge k -> outputs updated at edge k+2.
//  - h_pos = hrise ? 0 : hcnt+1; hcnt<=h_pos. v_pos = vrise ? 0 : hrise ? vcnt+1 : vcnt; vcnt<=v_pos.
//    Counters saturate (no wrap) at all-ones; overflow is covered by the length checks below.
//  - Active: h_pos in [HR+HB, HR+HB+HD-1] and v_pos in [VR+VB, VR+VB+VD-1].
//    addr_x_o=h_pos-(HR+HB), addr_y_o=v_pos-(VR+VB), truncated to port width; registered with we_o.
//  - color_o from s2.rgb MSBs r=[11],g=[7],b=[3]: r&g&b->WHITE; r&!g&!b->BLUE; !r&g&!b->GREEN; else BLACK.
//    (BLUE=R nibble set, matching the generator's encoding.)
//  - we_o=1 only in LOCKED and active; addr/color hold last values when we_o=0.
//  - Violations (checked in CHECK and LOCKED only):
//    V1 hrise with hcnt!=HMAX; V2 hfall with h_pos!=HR; V3 h_pos>HMAX with no hrise;
//    V4 vrise with vcnt!=VMAX or without simultaneous hrise; V5 vs falls at line other than v_pos==VR;
//    V6 v_pos>VMAX. Any violation: err_o pulse next cycle, FSM->SEARCH, we_o forced 0 same cycle.
//  - FSM: SEARCH: on vrise&hrise -> CHECK, good=0 (first frame start needs no length check).
//    CHECK: each error-free vrise: good++; when good reaches LOCK_FRAMES -> LOCKED.
//    LOCKED: frame_start_o pulses on each vrise; stays until violation or reset.
//  - Simultaneous violation and vrise: violation wins (no lock, no frame_start).
//  - Reset mid-frame: everything cleared asynchronously; relock needs LOCK_FRAMES full frames after next vrise.
// TESTING
//  1 Generator->capture loopback, small params (HD=8,HF=2,HR=3,HB=3,VD=4,VF=1,VR=2,VB=1), LOCK_FRAMES=2
//    -> locked_o rises at 2nd vrise after first; then 32 we_o per frame, x 0..7, y 0..3 raster order.
//  2 Constant rgb_i=12'hF00/0F0/FFF/000/F0F -> color_o=2/3/1/0/0 at every write.
//  3 While LOCKED stretch one line by 1 clk -> err_o one pulse, locked_o=0, we_o=0 until relock.
//  4 HS high for HR+1 clk in CHECK -> err_o, back to SEARCH; no we_o ever asserted.
//  5 vs held low (HS only) -> stays SEARCH, err_o never pulses, we_o=0.
//  6 arstn low mid-active-line while LOCKED -> all outputs 0 immediately; relock after LOCK_FRAMES frames.

Source files
------------

// File: rtl/vga_capture_if.sv
// Link between the VGA timing source and the capture block: sync/colour in, buffer write port and status out.
interface vga_capture_if #(
    parameter int unsigned HSYNC_BITS = 11,
    parameter int unsigned VSYNC_BITS = 11
);
    logic                  vga_hs_i;
    logic                  vga_vs_i;
    logic [11:0]           rgb_i;
    logic                  we_o;
    logic [HSYNC_BITS-1:0] addr_x_o;
    logic [VSYNC_BITS-1:0] addr_y_o;
    logic [1:0]            color_o;
    logic                  locked_o;
    logic                  frame_start_o;
    logic                  err_o;

    modport master (
        output vga_hs_i, vga_vs_i, rgb_i,
        input  we_o, addr_x_o, addr_y_o, color_o, locked_o, frame_start_o, err_o
    );

    modport slave (
        input  vga_hs_i, vga_vs_i, rgb_i,
        output we_o, addr_x_o, addr_y_o, color_o, locked_o, frame_start_o, err_o
    );
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel position from HS/VS, validates frame timing, locks,
// and writes 2-bit colour codes of active pixels into the video buffer.
module vga_capture #(
    parameter int unsigned HSYNC_BITS  = 11,
    parameter int unsigned VSYNC_BITS  = 11,
    parameter int unsigned HD          = 1280,
    parameter int unsigned HF          = 48,
    parameter int unsigned HR          = 112,
    parameter int unsigned HB          = 248,
    parameter int unsigned VD          = 1024,
    parameter int unsigned VF          = 1,
    parameter int unsigned VR          = 3,
    parameter int unsigned VB          = 38,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          arstn,
    vga_capture_if.slave  vga
);

    localparam int unsigned HMAX      = HD + HF + HR + HB - 1;
    localparam int unsigned VMAX      = VD + VF + VR + VB - 1;
    localparam int unsigned GOOD_BITS = $clog2(LOCK_FRAMES + 1);

    localparam logic [HSYNC_BITS-1:0] HMAX_C  = HSYNC_BITS'(HMAX);
    localparam logic [HSYNC_BITS-1:0] HR_C    = HSYNC_BITS'(HR);
    localparam logic [HSYNC_BITS-1:0] HACT_LO = HSYNC_BITS'(HR + HB);
    localparam logic [HSYNC_BITS-1:0] HACT_HI = HSYNC_BITS'(HR + HB + HD - 1);
    localparam logic [VSYNC_BITS-1:0] VMAX_C  = VSYNC_BITS'(VMAX);
    localparam logic [VSYNC_BITS-1:0] VR_C    = VSYNC_BITS'(VR);
    localparam logic [VSYNC_BITS-1:0] VACT_LO = VSYNC_BITS'(VR + VB);
    localparam logic [VSYNC_BITS-1:0] VACT_HI = VSYNC_BITS'(VR + VB + VD - 1);
    localparam logic [GOOD_BITS-1:0]  LOCK_C  = GOOD_BITS'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [1:0] COL_BLACK = 2'd0;
    localparam logic [1:0] COL_WHITE = 2'd1;
    localparam logic [1:0] COL_BLUE  = 2'd2;
    localparam logic [1:0] COL_GREEN = 2'd3;

    // Input synchroniser (s1, s2) plus one history stage for edge detection
    logic        s1_hs, s1_vs, s2_hs, s2_vs, s3_hs, s3_vs;
    logic [11:0] s1_rgb, s2_rgb;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_rgb <= '0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_rgb <= '0;
            s3_hs  <= 1'b0;
            s3_vs  <= 1'b0;
        end else begin
            s1_hs  <= vga.vga_hs_i;
            s1_vs  <= vga.vga_vs_i;
            s1_rgb <= vga.rgb_i;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_rgb <= s1_rgb;
            s3_hs  <= s2_hs;
            s3_vs  <= s2_vs;
        end
    end

    logic hrise, hfall, vrise, vfall;

    assign hrise = s2_hs & ~s3_hs;
    assign hfall = ~s2_hs & s3_hs;
    assign vrise = s2_vs & ~s3_vs;
    assign vfall = ~s2_vs & s3_vs;

    // Position counters saturate; runaway lines/frames are caught by the length checks
    logic [HSYNC_BITS-1:0] hcnt, h_inc, h_pos;
    logic [VSYNC_BITS-1:0] vcnt, v_inc, v_pos;

    assign h_inc = (&hcnt) ? hcnt : hcnt + HSYNC_BITS'(1);
    assign v_inc = (&vcnt) ? vcnt : vcnt + VSYNC_BITS'(1);
    assign h_pos = hrise ? '0 : h_inc;
    assign v_pos = vrise ? '0 : (hrise ? v_inc : vcnt);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_pos;
            vcnt <= v_pos;
        end
    end

    logic active;

    assign active = (h_pos >= HACT_LO) && (h_pos <= HACT_HI) &&
                    (v_pos >= VACT_LO) && (v_pos <= VACT_HI);

    // Timing violations; only acted upon once a frame start has been seen
    logic v_hlen, v_hsync, v_hlong, v_vstart, v_vsync, v_vlong, viol;

    assign v_hlen   = hrise && (hcnt != HMAX_C);
    assign v_hsync  = hfall && (h_pos != HR_C);
    assign v_hlong  = !hrise && (h_pos > HMAX_C);
    assign v_vstart = vrise && ((vcnt != VMAX_C) || !hrise);
    assign v_vsync  = vfall && (v_pos != VR_C);
    assign v_vlong  = v_pos > VMAX_C;
    assign viol     = v_hlen | v_hsync | v_hlong | v_vstart | v_vsync | v_vlong;

    // Colour code from channel MSBs; the generator encodes BLUE on the R nibble
    logic [1:0] color_c;

    always_comb begin
        color_c = COL_BLACK;
        case ({s2_rgb[11], s2_rgb[7], s2_rgb[3]})
            3'b111:  color_c = COL_WHITE;
            3'b100:  color_c = COL_BLUE;
            3'b010:  color_c = COL_GREEN;
            default: color_c = COL_BLACK;
        endcase
    end

    logic unused_rgb_bits;
    assign unused_rgb_bits = ^{s2_rgb[10:8], s2_rgb[6:4], s2_rgb[2:0]};

    logic [1:0]           state_q, state_d;
    logic [GOOD_BITS-1:0] good_q, good_d, good_inc;
    logic                 we_d, fs_d, err_d;

    assign good_inc = good_q + GOOD_BITS'(1);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Next state and output decode; a violation always wins over a frame start
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        we_d    = 1'b0;
        fs_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vrise && hrise) begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
            end
            ST_CHECK: begin
                if (viol) begin
                    state_d = ST_SEARCH;
                    err_d   = 1'b1;
                end else if (vrise) begin
                    good_d = good_inc;
                    if (good_inc == LOCK_C) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (viol) begin
                    state_d = ST_SEARCH;
                    err_d   = 1'b1;
                end else begin
                    we_d = active;
                    fs_d = vrise;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    logic                  we_q, fs_q, err_q, locked_q;
    logic [HSYNC_BITS-1:0] addr_x_q;
    logic [VSYNC_BITS-1:0] addr_y_q;
    logic [1:0]            color_q;

    // Write port registers; address and colour hold between writes
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            we_q     <= 1'b0;
            fs_q     <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            addr_x_q <= '0;
            addr_y_q <= '0;
            color_q  <= COL_BLACK;
        end else begin
            we_q     <= we_d;
            fs_q     <= fs_d;
            err_q    <= err_d;
            locked_q <= (state_d == ST_LOCKED);
            if (we_d) begin
                addr_x_q <= h_pos - HACT_LO;
                addr_y_q <= v_pos - VACT_LO;
                color_q  <= color_c;
            end
        end
    end

    assign vga.we_o          = we_q;
    assign vga.addr_x_o      = addr_x_q;
    assign vga.addr_y_o      = addr_y_q;
    assign vga.color_o       = color_q;
    assign vga.locked_o      = locked_q;
    assign vga.frame_start_o = fs_q;
    assign vga.err_o         = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: a small-raster timing source drives the link and a
// position/lock reference model predicts every output cycle by cycle.
module tb_vga_capture;

    localparam int HSB = 11;
    localparam int VSB = 11;
    localparam int HD = 8, HF = 2, HR = 3, HB = 3;
    localparam int VD = 4, VF = 1, VR = 2, VB = 1;
    localparam int LOCK = 2;
    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam int HSAT = (1 << HSB) - 1;
    localparam int VSAT = (1 << VSB) - 1;

    logic clk = 1'b0;
    logic arstn = 1'b0;

    always #5 clk = ~clk;

    vga_capture_if #(.HSYNC_BITS(HSB), .VSYNC_BITS(VSB)) vif ();

    vga_capture #(
        .HSYNC_BITS(HSB), .VSYNC_BITS(VSB),
        .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB),
        .LOCK_FRAMES(LOCK)
    ) dut (
        .clk   (clk),
        .arstn (arstn),
        .vga   (vif)
    );

    int n_chk = 0;
    int n_err = 0;
    int we_cnt = 0;
    int err_cnt = 0;
    int lit_col = -1;
    int r_idx = 0;
    bit const_en = 1'b0;
    logic [11:0] const_rgb = '0;
    bit rel_pending = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: positions as plain integers derived from observed sync edges
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } smp_t;

    smp_t sq[$];
    int   m_hpos, m_vpos, m_good;
    bit   m_phs, m_pvs, m_check, m_lock;
    bit   e_we, e_fs, e_err, e_lock;
    int   e_x, e_y, e_col;

    function automatic int colour_of(input logic [11:0] rgb);
        logic [2:0] m;
        m = {rgb[11], rgb[7], rgb[3]};
        if (m == 3'b111) return 1;
        if (m == 3'b100) return 2;
        if (m == 3'b010) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        sq.delete();
        sq.push_back('0);
        sq.push_back('0);
        m_hpos = 0; m_vpos = 0; m_good = 0;
        m_phs = 0; m_pvs = 0; m_check = 0; m_lock = 0;
        e_we = 0; e_fs = 0; e_err = 0; e_lock = 0;
        e_x = 0; e_y = 0; e_col = 0;
    endtask

    task automatic model_step(input smp_t s);
        bit hr, hf, vr, vf, in_act, bad;
        int hp, vp;
        hr = s.hs && !m_phs;
        hf = !s.hs && m_phs;
        vr = s.vs && !m_pvs;
        vf = !s.vs && m_pvs;
        hp = hr ? 0 : ((m_hpos + 1 > HSAT) ? HSAT : m_hpos + 1);
        vp = vr ? 0 : (hr ? ((m_vpos + 1 > VSAT) ? VSAT : m_vpos + 1) : m_vpos);
        in_act = (hp >= HR + HB) && (hp < HR + HB + HD) && (vp >= VR + VB) && (vp < VR + VB + VD);
        bad = m_check && ((hr && m_hpos != HT - 1) || (hf && hp != HR) || (!hr && hp > HT - 1) ||
                          (vr && (m_vpos != VT - 1 || !hr)) || (vf && vp != VR) || (vp > VT - 1));
        e_err = bad;
        e_fs  = m_lock && vr && !bad;
        e_we  = m_lock && in_act && !bad;
        if (e_we) begin
            e_x   = hp - (HR + HB);
            e_y   = vp - (VR + VB);
            e_col = colour_of(s.rgb);
        end
        if (bad) begin
            m_check = 0;
            m_lock  = 0;
        end else if (!m_check) begin
            if (vr && hr) begin
                m_check = 1;
                m_good  = 0;
            end
        end else if (!m_lock && vr) begin
            m_good++;
            if (m_good >= LOCK) m_lock = 1;
        end
        e_lock = m_lock;
        m_hpos = hp;
        m_vpos = vp;
        m_phs  = s.hs;
        m_pvs  = s.vs;
    endtask

    // Compare process: model advances on each edge, DUT outputs checked 1 ns later
    always begin
        @(posedge clk);
        if (!arstn) begin
            model_reset();
            r_idx = 0;
        end else begin
            sq.push_back({vif.vga_hs_i, vif.vga_vs_i, vif.rgb_i});
            model_step(sq.pop_front());
        end
        #1;
        chk("we_o", int'(vif.we_o), int'(e_we));
        chk("frame_start_o", int'(vif.frame_start_o), int'(e_fs));
        chk("err_o", int'(vif.err_o), int'(e_err));
        chk("locked_o", int'(vif.locked_o), int'(e_lock));
        chk("addr_x_o", int'(vif.addr_x_o), e_x);
        chk("addr_y_o", int'(vif.addr_y_o), e_y);
        chk("color_o", int'(vif.color_o), e_col);
        if (!vif.locked_o) r_idx = 0;
        if (vif.we_o) begin
            chk("raster_x", int'(vif.addr_x_o), r_idx % HD);
            chk("raster_y", int'(vif.addr_y_o), r_idx / HD);
            if (lit_col >= 0) chk("const_color", int'(vif.color_o), lit_col);
            r_idx++;
            we_cnt++;
        end
        if (vif.frame_start_o) begin
            chk("frame_writes", r_idx, HD * VD);
            r_idx = 0;
        end
        if (vif.err_o) err_cnt++;
    end

    task automatic chk_outputs_zero();
        chk("rst_we", int'(vif.we_o), 0);
        chk("rst_addr_x", int'(vif.addr_x_o), 0);
        chk("rst_addr_y", int'(vif.addr_y_o), 0);
        chk("rst_color", int'(vif.color_o), 0);
        chk("rst_locked", int'(vif.locked_o), 0);
        chk("rst_frame_start", int'(vif.frame_start_o), 0);
        chk("rst_err", int'(vif.err_o), 0);
    endtask

    // One raster line; stretch adds front-porch clocks, hs_extra lengthens the sync pulse
    task automatic drive_line(input int l, input int stretch, input int hs_extra,
                              input bit vs_en, input int rst_at);
        for (int p = 0; p < HT + stretch; p++) begin
            @(negedge clk);
            if (rel_pending) begin
                arstn = 1'b1;
                rel_pending = 1'b0;
            end
            vif.vga_hs_i = (p < HR + hs_extra);
            vif.vga_vs_i = vs_en && (l < VR);
            vif.rgb_i    = const_en ? const_rgb : 12'($urandom);
            if (p == rst_at) begin
                chk("pre_rst_locked", int'(vif.locked_o), 1);
                #2 arstn = 1'b0;
                #1 chk_outputs_zero();
                rel_pending = 1'b1;
            end
        end
    endtask

    task automatic drive_frame(input int stretch_line, input int long_hs_line,
                               input int rst_line, input int rst_px);
        for (int l = 0; l < VT; l++) begin
            drive_line(l, (l == stretch_line) ? 1 : 0, (l == long_hs_line) ? 1 : 0, 1'b1,
                       (l == rst_line) ? rst_px : -1);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) drive_frame(-1, -1, -1, -1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        arstn = 1'b0;
        #1 chk_outputs_zero();
        @(negedge clk);
        arstn = 1'b1;
    endtask

    logic [11:0] crgb [5] = '{12'hF00, 12'h0F0, 12'hFFF, 12'h000, 12'hF0F};
    int          ccol [5] = '{2, 3, 1, 0, 0};

    initial begin
        int e0, w0, w1;
        vif.vga_hs_i = 1'b0;
        vif.vga_vs_i = 1'b0;
        vif.rgb_i    = '0;
        repeat (3) @(negedge clk);
        arstn = 1'b1;

        // HS only, VS never rises: must stay searching
        e0 = err_cnt; w0 = we_cnt;
        for (int l = 0; l < 4; l++) drive_line(l, 0, 0, 1'b0, -1);
        chk("hs_only_err", err_cnt - e0, 0);
        chk("hs_only_we", we_cnt - w0, 0);
        chk("hs_only_locked", int'(vif.locked_o), 0);

        // Clean loopback: lock on the third frame start
        e0 = err_cnt; w0 = we_cnt;
        frames(2);
        chk("not_yet_locked", int'(vif.locked_o), 0);
        chk("no_we_before_lock", we_cnt - w0, 0);
        frames(3);
        chk("locked_after_3", int'(vif.locked_o), 1);
        chk("writes_3_frames", we_cnt - w0, 3 * HD * VD);
        chk("clean_err", err_cnt - e0, 0);

        // Constant colours
        const_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            const_rgb = crgb[i];
            lit_col   = ccol[i];
            w0 = we_cnt;
            frames(1);
            chk("const_frame_writes", we_cnt - w0, HD * VD);
        end
        const_en = 1'b0;
        lit_col  = -1;

        // Stretched line while locked
        e0 = err_cnt;
        drive_frame(5, -1, -1, -1);
        chk("stretch_err_pulses", err_cnt - e0, 1);
        chk("stretch_unlocked", int'(vif.locked_o), 0);
        w1 = we_cnt;
        frames(2);
        chk("stretch_no_we", we_cnt - w1, 0);
        chk("stretch_still_unlocked", int'(vif.locked_o), 0);
        frames(1);
        chk("stretch_relocked", int'(vif.locked_o), 1);
        chk("stretch_err_total", err_cnt - e0, 1);

        // Over-long HS while checking
        reset_pulse();
        e0 = err_cnt; w0 = we_cnt;
        drive_frame(-1, 1, -1, -1);
        chk("long_hs_err", err_cnt - e0, 1);
        frames(1);
        chk("long_hs_no_we", we_cnt - w0, 0);
        chk("long_hs_unlocked", int'(vif.locked_o), 0);

        // Reset in the middle of an active line while locked
        frames(2);
        chk("pre_reset_lock", int'(vif.locked_o), 1);
        drive_frame(-1, -1, 4, 8);
        chk("post_reset_unlocked", int'(vif.locked_o), 0);
        frames(2);
        chk("relock_pending", int'(vif.locked_o), 0);
        w0 = we_cnt;
        frames(1);
        chk("relocked", int'(vif.locked_o), 1);
        chk("relock_frame_writes", we_cnt - w0, HD * VD);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
